// File: rtl/dvi_rx_decode.sv
// dvi_rx_decode: TMDS decoder for one DVI receive channel.
//
// Takes one 10-bit TMDS word per pixel clock from the deserializer and
// recovers de, the data byte and the c0/c1 control bits through a fixed
// 2-register pipeline (in_d -> outputs in exactly 2 clocks, no stalls).
//
// Optional feature macro: DVI_RX_DECODE_ALIGN_EN
//   defined   : word-alignment FSM (SEARCH/SLIP/LOCKED) drives bitslip and
//               aligned from how reliably control tokens decode.
//   undefined : no FSM or counters; bitslip is tied 0 and aligned is 1 from
//               the first clock after reset (0 while in reset).
//
// Ports:
//   clk      in   1   pixel clock
//   reset_n  in   1   asynchronous active-low reset
//   in_d     in   10  TMDS word, bit 0 first on the wire
//   out_de   out  1   1 = out_d is pixel data, 0 = blanking
//   out_d    out  8   decoded data byte (00 on control words)
//   out_c0   out  1   control bit 0 (held during data words)
//   out_c1   out  1   control bit 1 (held during data words)
//   bitslip  out  1   one-cycle request to shift the deserializer by one bit
//   aligned  out  1   1 = alignment FSM in LOCKED
module dvi_rx_decode #(
  parameter int unsigned SEARCH_LEN   = 4096,
  parameter int unsigned CTRL_RUN     = 16,
  parameter int unsigned SLIP_WAIT    = 8,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [9:0] in_d,
  output logic       out_de,
  output logic [7:0] out_d,
  output logic       out_c0,
  output logic       out_c1,
  output logic       bitslip,
  output logic       aligned
);

  // Exact-match control token detector: returns {is_ctrl, c1, c0}.
  function automatic logic [2:0] ctrl_match(input logic [9:0] w);
    case (w)
      10'b1101010100: return 3'b100;
      10'b0010101011: return 3'b101;
      10'b0101010100: return 3'b110;
      10'b1010101011: return 3'b111;
      default:        return 3'b000;
    endcase
  endfunction

  // Inverse of the TMDS transition-minimising stage: bit 9 undoes the
  // DC-balance inversion, bit 8 selects XOR or XNOR chaining.
  function automatic logic [7:0] tmds_data(input logic [9:0] w);
    logic [7:0] t;
    logic [7:0] d;
    t    = w[9] ? ~w[7:0] : w[7:0];
    d    = '0;
    d[0] = t[0];
    for (int i = 1; i < 8; i++) begin
      d[i] = w[8] ? (t[i] ^ t[i-1]) : ~(t[i] ^ t[i-1]);
    end
    return d;
  endfunction

  logic [9:0] word_p1_q;
  logic       vld_p1_q;
  logic       ctrl_p1_q;
  logic [1:0] code_p1_q;
  logic       de_p2_q;
  logic [7:0] d_p2_q;
  logic       c0_p2_q;
  logic       c1_p2_q;

  // ---- stage 1: register the raw word and its control-token classification
  always_ff @(posedge clk) begin
    word_p1_q <= in_d;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p1_q  <= 1'b0;
      ctrl_p1_q <= 1'b0;
      code_p1_q <= 2'b00;
    end else begin
      vld_p1_q               <= 1'b1;
      {ctrl_p1_q, code_p1_q} <= ctrl_match(in_d);
    end
  end

  // ---- stage 2: decoded outputs; the first post-reset cycle carries no word
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      de_p2_q <= 1'b0;
      d_p2_q  <= 8'h00;
      c0_p2_q <= 1'b0;
      c1_p2_q <= 1'b0;
    end else if (vld_p1_q) begin
      if (ctrl_p1_q) begin
        de_p2_q            <= 1'b0;
        d_p2_q             <= 8'h00;
        {c1_p2_q, c0_p2_q} <= code_p1_q;
      end else begin
        de_p2_q <= 1'b1;
        d_p2_q  <= tmds_data(word_p1_q);
      end
    end
  end

  assign out_de = de_p2_q;
  assign out_d  = d_p2_q;
  assign out_c0 = c0_p2_q;
  assign out_c1 = c1_p2_q;

`ifdef DVI_RX_DECODE_ALIGN_EN
  localparam int unsigned IdleMax = (SEARCH_LEN > LOCK_TIMEOUT) ? SEARCH_LEN : LOCK_TIMEOUT;
  localparam int IdleW = $clog2(IdleMax + 1);
  localparam int RunW  = $clog2(CTRL_RUN + 1);
  localparam int SlipW = $clog2(SLIP_WAIT + 1);

  typedef enum logic [1:0] {S_SEARCH, S_SLIP, S_LOCKED} state_e;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] lim);
    return (v >= lim) ? v : v + 32'd1;
  endfunction

  state_e           state_q;
  logic [IdleW-1:0] idle_q;
  logic [RunW-1:0]  run_q;
  logic [SlipW-1:0] slip_q;
  logic             bitslip_q;
  logic             aligned_q;
  logic [IdleW-1:0] idle_d;
  logic [RunW-1:0]  run_d;
  logic [SlipW-1:0] slip_d;
  logic             ctrl_seen;
  logic             data_seen;

  always_comb begin
    idle_d    = IdleW'(sat_inc(32'(idle_q), IdleMax));
    run_d     = RunW'(sat_inc(32'(run_q), CTRL_RUN));
    slip_d    = SlipW'(sat_inc(32'(slip_q), SLIP_WAIT));
    ctrl_seen = vld_p1_q & ctrl_p1_q;
    data_seen = vld_p1_q & ~ctrl_p1_q;
  end

  // Transitions fire on the edge where a counter's next value reaches its
  // limit, so aligned rises together with the output of the CTRL_RUN-th
  // token. A control word always takes precedence over an idle limit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_SEARCH;
      idle_q    <= '0;
      run_q     <= '0;
      slip_q    <= '0;
      bitslip_q <= 1'b0;
      aligned_q <= 1'b0;
    end else begin
      bitslip_q <= 1'b0;
      case (state_q)
        S_SEARCH: begin
          if (ctrl_seen) begin
            idle_q <= '0;
            if (run_d == RunW'(CTRL_RUN)) begin
              state_q   <= S_LOCKED;
              aligned_q <= 1'b1;
              run_q     <= '0;
            end else begin
              run_q <= run_d;
            end
          end else if (data_seen) begin
            run_q <= '0;
            if (idle_d == IdleW'(SEARCH_LEN)) begin
              state_q   <= S_SLIP;
              bitslip_q <= 1'b1;
              idle_q    <= '0;
              slip_q    <= '0;
            end else begin
              idle_q <= idle_d;
            end
          end
        end
        S_SLIP: begin
          // Deserializer is settling: input ignored, no further slips.
          if (slip_d == SlipW'(SLIP_WAIT)) begin
            state_q <= S_SEARCH;
            slip_q  <= '0;
            idle_q  <= '0;
            run_q   <= '0;
          end else begin
            slip_q <= slip_d;
          end
        end
        S_LOCKED: begin
          if (ctrl_seen) begin
            idle_q <= '0;
          end else if (idle_d == IdleW'(LOCK_TIMEOUT)) begin
            state_q   <= S_SEARCH;
            aligned_q <= 1'b0;
            idle_q    <= '0;
            run_q     <= '0;
          end else begin
            idle_q <= idle_d;
          end
        end
        default: state_q <= S_SEARCH;
      endcase
    end
  end

  assign bitslip = bitslip_q;
  assign aligned = aligned_q;
`else
  logic        aligned_q;
  logic [31:0] unused_cfg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      aligned_q <= 1'b0;
    end else begin
      aligned_q <= 1'b1;
    end
  end

  assign unused_cfg = 32'(SEARCH_LEN ^ CTRL_RUN ^ SLIP_WAIT ^ LOCK_TIMEOUT);
  assign bitslip    = 1'b0;
  assign aligned    = aligned_q;
`endif

endmodule
